pwm_duty_capture: RTL

- Receive-side counterpart of the breathing-LED PWM generator.
- Samples an asynchronous PWM waveform, such as the LED drive looped back, and measures its period and high time in 2 us ticks.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a stuck line (no edges within a timeout). Used for on-board self-check of LED/PWM outputs and for decoding an external PWM setpoint.

---
 rtl/pwm_duty_capture.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_capture.sv
// Measures period and high time of an asynchronous PWM line in prescaled ticks,
// strobing each completed rise-to-rise measurement and flagging a stuck line.
module pwm_duty_capture #(
    parameter logic [6:0]       CNT_2US_MAX = 7'd99,
    parameter int               CNT_W       = 11,
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = 11'd1500
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // Handshake: meas_valid is a single-cycle strobe with no back-pressure;
    // period_out/high_out change only in the cycle meas_valid is high.

    logic             sync_meta, sync_q, hist_q;
    logic [2:0]       fill_q;
    logic             edge_ok, rise, fall, tick, timeout_hit;
    logic [6:0]       presc, presc_base, presc_nxt;
    logic [CNT_W-1:0] period_cnt, high_cnt, high_lat;
    state_t           state_q, state_d;
    logic             clear_cnt, latch_high, publish;

    // fill_q marks which pipeline stages hold real samples since reset, so the
    // refill after reset can never be mistaken for an edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            hist_q    <= 1'b0;
            fill_q    <= '0;
        end else begin
            sync_meta <= pwm_in;
            sync_q    <= sync_meta;
            hist_q    <= sync_q;
            fill_q    <= {fill_q[1:0], 1'b1};
        end
    end

    assign edge_ok = fill_q[2];
    assign rise    = edge_ok & sync_q & ~hist_q;
    assign fall    = edge_ok & ~sync_q & hist_q;

    // The rise cycle acts as prescaler phase 0, so the first tick lands
    // CNT_2US_MAX cycles after it.
    assign presc_base  = rise ? 7'd0 : presc;
    assign presc_nxt   = (presc_base == CNT_2US_MAX) ? 7'd0 : presc_base + 7'd1;
    assign tick        = (presc == CNT_2US_MAX) & ~rise;
    assign timeout_hit = (period_cnt == TIMEOUT_MAX) & ~rise;

    always_comb begin
        state_d    = state_q;
        clear_cnt  = 1'b0;
        latch_high = 1'b0;
        publish    = 1'b0;
        if (rise) begin
            state_d   = HIGH;
            clear_cnt = 1'b1;
            publish   = (state_q == LOW);
        end else if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall && state_q == HIGH) begin
            state_d    = LOW;
            latch_high = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc       <= '0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            high_lat    <= '0;
            state_q     <= IDLE;
            period_out  <= '0;
            high_out    <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            state_q    <= state_d;
            meas_valid <= publish;

            if (clear_cnt) begin
                period_cnt <= '0;
                high_cnt   <= '0;
            end else begin
                if (tick && period_cnt != TIMEOUT_MAX)
                    period_cnt <= period_cnt + 1'b1;
                if (tick && state_q == HIGH && !fall && high_cnt != TIMEOUT_MAX)
                    high_cnt <= high_cnt + 1'b1;
            end

            if (latch_high)
                high_lat <= high_cnt;

            if (publish) begin
                period_out <= period_cnt;
                high_out   <= high_lat;
            end

            // stuck_level records the line level at the moment of timeout only.
            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout_hit && !stuck) begin
                stuck       <= 1'b1;
                stuck_level <= sync_q;
            end
        end
    end

endmodule
